// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate cache sitting between
// the CPU pipeline and an SRAM controller. One 32-bit word per line, one LRU bit per set.
module cache_controller #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_read_en,
  output logic        sram_write_en,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int TAG_W = 17 - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } state_t;

  state_t state;

  logic [SETS-1:0]  valid0, valid1, lru;
  logic [TAG_W-1:0] tag0  [SETS];
  logic [TAG_W-1:0] tag1  [SETS];
  logic [31:0]      data0 [SETS];
  logic [31:0]      data1 [SETS];

  logic [31:0] addr_q, wdata_q;

  // In IDLE the lookup uses the live CPU address; in the busy states the latched one,
  // so CPU inputs that wander during a transaction have no effect.
  logic [31:0]        lookup_addr;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit0, hit1, hit, victim;
  logic               unused_addr_bits;

  assign lookup_addr      = (state == IDLE) ? address : addr_q;
  assign idx              = lookup_addr[INDEX_W+1:2];
  assign tag              = lookup_addr[18:INDEX_W+2];
  assign unused_addr_bits = ^{lookup_addr[31:19], lookup_addr[1:0]};

  assign hit0   = valid0[idx] && (tag0[idx] == tag);
  assign hit1   = valid1[idx] && (tag1[idx] == tag);
  assign hit    = hit0 || hit1;
  // First invalid way wins; with both valid the LRU bit names the victim.
  assign victim = !valid0[idx] ? 1'b0 : (!valid1[idx] ? 1'b1 : lru[idx]);

  assign sram_address  = addr_q;
  assign sram_wdata    = wdata_q;
  assign sram_read_en  = (state == READ_MISS);
  assign sram_write_en = (state == WRITE);

  always_comb begin
    ready = 1'b1;
    rdata = hit1 ? data1[idx] : data0[idx];
    unique case (state)
      IDLE:      ready = MEM_W_EN ? 1'b0 : (MEM_R_EN ? hit : 1'b1);
      READ_MISS: begin
        ready = sram_ready;
        rdata = sram_rdata;
      end
      WRITE:     ready = sram_ready;
      default:   ready = 1'b1;
    endcase
  end

  // NOTE: only valid/LRU bits and the state need reset; tag/data arrays are gated by
  // valid, so leaving them unreset keeps them plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (MEM_W_EN) begin
            state <= WRITE;
          end else if (MEM_R_EN) begin
            if (hit) lru[idx] <= hit0;
            else     state    <= READ_MISS;
          end
        end
        READ_MISS: begin
          if (sram_ready) begin
            if (victim) valid1[idx] <= 1'b1;
            else        valid0[idx] <= 1'b1;
            lru[idx] <= ~victim;
            state    <= IDLE;
          end
        end
        WRITE: begin
          if (sram_ready) begin
            if (hit) lru[idx] <= hit0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request latches and the tag/data arrays; a reset at the completing edge blocks the update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && (MEM_W_EN || MEM_R_EN)) begin
        addr_q  <= address;
        wdata_q <= wdata;
      end
      if (state == READ_MISS && sram_ready) begin
        if (victim) begin
          tag1[idx]  <= tag;
          data1[idx] <= sram_rdata;
        end else begin
          tag0[idx]  <= tag;
          data0[idx] <= sram_rdata;
        end
      end
      if (state == WRITE && sram_ready) begin
        if (hit0)      data0[idx] <= wdata_q;
        else if (hit1) data1[idx] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: every access is hand-sequenced against an SRAM
// stand-in whose latency and returned word are chosen per step.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, wdata, rdata, sram_address, sram_wdata, sram_rdata;
  logic        MEM_R_EN, MEM_W_EN, ready, sram_read_en, sram_write_en, sram_ready;

  int tests  = 0;
  int failed = 0;

  cache_controller #(.INDEX_W(6)) dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Drives at the falling edge, samples 1 time unit later, well clear of the rising edge.
  task automatic do_read(input logic [31:0] addr, input bit exp_hit,
                         input logic [31:0] word, input int lat);
    @(negedge clk);
    address = addr; MEM_R_EN = 1'b1; sram_ready = 1'b1; sram_rdata = 32'h0BAD_0BAD;
    #1;
    if (exp_hit) begin
      check("hit_ready", {31'd0, ready}, 32'd1);
      check("hit_rdata", rdata, word);
      check("hit_no_sram_read", {31'd0, sram_read_en}, 32'd0);
      @(negedge clk);
      MEM_R_EN = 1'b0; sram_ready = 1'b0;
    end else begin
      check("miss_ready_low", {31'd0, ready}, 32'd0);
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        sram_ready = 1'b0; address = 32'hFFFF_FFFC;
        #1;
        check("rm_read_en", {31'd0, sram_read_en}, 32'd1);
        check("rm_ready_low", {31'd0, ready}, 32'd0);
        check("rm_sram_addr", sram_address, addr);
      end
      @(negedge clk);
      sram_ready = 1'b1; sram_rdata = word; address = 32'hFFFF_FFFC;
      #1;
      check("rm_done_ready", {31'd0, ready}, 32'd1);
      check("rm_done_rdata", rdata, word);
      @(negedge clk);
      sram_ready = 1'b0; MEM_R_EN = 1'b0; address = addr;
      #1;
      check("rm_after_read_en", {31'd0, sram_read_en}, 32'd0);
      check("rm_after_ready", {31'd0, ready}, 32'd1);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input int lat, input bit both);
    @(negedge clk);
    address = addr; wdata = data; MEM_W_EN = 1'b1; MEM_R_EN = both; sram_ready = 1'b1;
    #1;
    check("wr_ready_low", {31'd0, ready}, 32'd0);
    check("wr_idle_no_en", {30'd0, sram_read_en, sram_write_en}, 32'd0);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      sram_ready = 1'b0; address = 32'hFFFF_FFFC; wdata = 32'h0;
      #1;
      check("wr_enables", {30'd0, sram_read_en, sram_write_en}, 32'd1);
      check("wr_ready_hold", {31'd0, ready}, 32'd0);
      check("wr_sram_addr", sram_address, addr);
      check("wr_sram_wdata", sram_wdata, data);
    end
    @(negedge clk);
    sram_ready = 1'b1;
    #1;
    check("wr_done_ready", {31'd0, ready}, 32'd1);
    check("wr_done_enables", {30'd0, sram_read_en, sram_write_en}, 32'd1);
    @(negedge clk);
    sram_ready = 1'b0; MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
    #1;
    check("wr_after_enables", {30'd0, sram_read_en, sram_write_en}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; address = '0; wdata = '0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    sram_rdata = '0; sram_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_enables", {30'd0, sram_read_en, sram_write_en}, 32'd0);

    // Cold read with 5 stall cycles in READ_MISS, then a repeat hit.
    do_read(32'h0000_0500, 1'b0, 32'hDEAD_BEEF, 5);
    do_read(32'h0000_0500, 1'b1, 32'hDEAD_BEEF, 0);

    // All of 0x500/0x900/0xD00/0x600/0x700 map to set 0 with distinct tags.
    do_read(32'h0000_0900, 1'b0, 32'h9999_0009, 2);   // fills way1
    do_read(32'h0000_0500, 1'b1, 32'hDEAD_BEEF, 0);   // way0 recent, way1 is LRU
    do_read(32'h0000_0D00, 1'b0, 32'hDDDD_000D, 1);   // evicts 0x900
    do_read(32'h0000_0500, 1'b1, 32'hDEAD_BEEF, 0);
    do_read(32'h0000_0D00, 1'b1, 32'hDDDD_000D, 0);
    do_read(32'h0000_0900, 1'b0, 32'h9999_0009, 1);   // evicted earlier; now replaces 0x500
    do_read(32'h0000_0900, 1'b1, 32'h9999_0009, 0);
    do_read(32'h0000_0D00, 1'b1, 32'hDDDD_000D, 0);   // way1 recent, 0x900 now LRU

    // Write hit on 0x900 updates the cached copy.
    do_write(32'h0000_0900, 32'h1234_5678, 3, 1'b0);
    do_read(32'h0000_0900, 1'b1, 32'h1234_5678, 0);

    // Write miss does not allocate.
    do_write(32'h0000_0600, 32'h6060_6060, 2, 1'b0);
    do_read(32'h0000_0600, 1'b0, 32'h6666_6666, 1);   // victim way1 (0xD00)

    // Reset on the third READ_MISS cycle aborts the fill.
    @(negedge clk);
    address = 32'h0000_0D00; MEM_R_EN = 1'b1;
    #1;
    check("abort_miss_ready", {31'd0, ready}, 32'd0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b1; MEM_R_EN = 1'b0;
    #1;
    check("abort_read_en_before", {31'd0, sram_read_en}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_read_en_after", {31'd0, sram_read_en}, 32'd0);
    check("abort_ready_after", {31'd0, ready}, 32'd1);
    do_read(32'h0000_0900, 1'b0, 32'hCAFE_F00D, 0);   // valid bits were cleared
    do_read(32'h0000_0900, 1'b1, 32'hCAFE_F00D, 0);

    // Simultaneous load and store: the store wins.
    do_write(32'h0000_0700, 32'h7777_7777, 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The module SHALL take parameter INDEX_W, default 6, as the set-index width (64 sets); the tag width SHALL be 17-INDEX_W (11 at default).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port address, input, 32 bits: CPU byte address; bits [18:2] are the word address, [INDEX_W+1:2] the index, [18:INDEX_W+2] the tag.
REQ-005 The module SHALL have port wdata, input, 32 bits: CPU store data.
REQ-006 The module SHALL have ports MEM_R_EN and MEM_W_EN, input, 1 bit each: CPU load and store requests, held until ready.
REQ-007 The module SHALL have port rdata, output, 32 bits: load data, valid when ready=1 with MEM_R_EN=1.
REQ-008 The module SHALL have port ready, output, 1 bit: request complete; CPU pipeline freezes while 0.
REQ-009 The module SHALL have ports sram_address and sram_wdata, output, 32 bits each: the latched CPU address and data, passed unmodified to the SRAM controller.
REQ-010 The module SHALL have ports sram_read_en and sram_write_en, output, 1 bit each: SRAM controller requests.
REQ-011 The module SHALL have port sram_rdata, input, 32 bits: SRAM read word.
REQ-012 The module SHALL have port sram_ready, input, 1 bit: SRAM transaction-done pulse.

Function
REQ-013 Organisation SHALL be 2-way set-associative, one 32-bit word per line, with per-way valid bit, tag and data, and one LRU bit per set.
REQ-014 Policy SHALL be write-through with no write-allocate.
REQ-015 States SHALL be IDLE, READ_MISS and WRITE, encoded in a 2-bit register.
REQ-016 In IDLE with MEM_R_EN=1 and a hit (a valid way whose tag matches), ready and rdata (the hit way's data) SHALL be driven combinationally in the same cycle, the state SHALL stay IDLE, and the LRU bit SHALL be updated at the clock edge.
REQ-017 In IDLE with MEM_R_EN=1 and a miss, ready SHALL be 0, address SHALL be latched, and the next state SHALL be READ_MISS.
REQ-018 In IDLE with MEM_W_EN=1, ready SHALL be 0, address and wdata SHALL be latched, and the next state SHALL be WRITE, whether the access hits or misses.
REQ-019 When MEM_R_EN and MEM_W_EN are both 1 in IDLE, the write SHALL take priority.
REQ-020 In IDLE with no request, ready SHALL be 1 and both SRAM enables SHALL be 0.
REQ-021 READ_MISS SHALL hold sram_read_en=1 and ready=0 until sram_ready=1.
REQ-022 In the READ_MISS cycle with sram_ready=1: ready=1, rdata=sram_rdata; at the edge the victim way SHALL be filled (valid=1, tag, data), LRU updated, next state IDLE.
REQ-023 The victim SHALL be the first invalid way (way0 before way1); if both ways are valid, the victim SHALL be the way indicated by the LRU bit.
REQ-024 LRU encoding SHALL be: lru=0 means way0 is the victim; an access to way0 sets lru=1, an access to way1 sets lru=0.
REQ-025 WRITE SHALL hold sram_write_en=1 and ready=0 until sram_ready=1.
REQ-026 In the WRITE cycle with sram_ready=1: ready=1; at the edge, on a hit the hit way's data SHALL be replaced with the latched wdata and LRU updated, on a miss the arrays SHALL be unchanged; next state IDLE.
REQ-027 sram_ready SHALL be ignored in IDLE, because the SRAM controller reports ready=1 when idle.
REQ-028 CPU inputs that change during READ_MISS or WRITE SHALL be ignored; the latched values SHALL complete the transaction.
REQ-029 sram_read_en and sram_write_en SHALL never be 1 simultaneously and SHALL be driven only from the state register.

Reset
REQ-030 rst=1 at an edge SHALL set state=IDLE, clear all valid bits and LRU bits, and force sram_read_en=0 and sram_write_en=0 from the following cycle; tag and data contents SHALL be don't-care.
REQ-031 Reset asserted mid READ_MISS or WRITE SHALL abort the transaction without an array update; ready SHALL then be 1 in IDLE with no request.

Verification
REQ-032 Cold read: after reset, MEM_R_EN at 0x0000_0500 with SRAM model returning 0xDEADBEEF after 5 cycles -> ready=0 for 6 cycles, then ready=1 with rdata=0xDEADBEEF; a repeat read SHALL hit with ready=1 in the same cycle.
REQ-033 Way fill/eviction: read 0x500, then 0x900 (same index, tag differs), then 0x500, then 0xD00 -> way0 and way1 are filled, 0x900 (LRU) is evicted, and a subsequent 0x500 read hits.
REQ-034 Write hit: cached 0x500, store 0x12345678 -> sram_write_en held until sram_ready and ready asserted on sram_ready; a next read of 0x500 SHALL hit with 0x12345678 and no sram_read_en.
REQ-035 Write miss: store to uncached 0x600 -> SRAM write occurs, a read of 0x600 then misses (no allocate).
REQ-036 Reset mid-miss: rst pulsed on the third READ_MISS cycle -> sram_read_en=0 next cycle, and a read of 0x500 afterwards misses.
REQ-037 Simultaneous MEM_R_EN and MEM_W_EN at 0x700 -> only sram_write_en is asserted.
